// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch controller in front of a combinational instruction memory.
// It holds the fetch PC, drives the word address to the memory and captures
// each returned instruction, together with its byte PC, into a small in-order
// fetch queue. The queue head is offered to decode through a valid/ready
// handshake. A redirect flushes the queue and restarts fetch at a new PC, and
// fetch_en stalls new fetches while letting the queue drain.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-high reset
//   fetch_en       1 = fetch allowed; 0 = hold PC, no new pushes
//   redirect_valid 1 = flush queue and restart fetch at redirect_pc
//   redirect_pc    new byte PC (bits [1:0] ignored)
//   imem_addr      word address to the instruction memory
//   imem_data      instruction returned combinationally for imem_addr
//   out_valid      queue head valid to decode
//   out_ready      decode accepts the head
//   out_instr      head instruction
//   out_pc         head byte PC
//   queue_count    current queue occupancy
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int unsigned ADDR_WIDTH  = 5,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned QUEUE_DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           fetch_en,
    input  logic                           redirect_valid,
    input  logic [31:0]                    redirect_pc,
    output logic [ADDR_WIDTH-1:0]          imem_addr,
    input  logic [31:0]                    imem_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [31:0]                    out_instr,
    output logic [31:0]                    out_pc,
    output logic [$clog2(QUEUE_DEPTH):0]   queue_count
);

    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);
    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    logic [31:0]      fetch_pc;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [31:0]      entry_pc    [QUEUE_DEPTH];
    logic [31:0]      entry_instr [QUEUE_DEPTH];

    logic        pop;
    logic        push;
    logic [31:0] redirect_pc_aligned;

    assign redirect_pc_aligned = redirect_pc & ~32'd3;

    // A redirect masks the head so decode can never consume an entry that is
    // being flushed in the same cycle.
    assign out_valid = (count != '0) && !redirect_valid;
    assign pop       = out_valid && out_ready;
    // A pop frees a slot this cycle, so a full queue still accepts one word
    // and sustains one instruction per cycle.
    assign push      = fetch_en && !redirect_valid && ((count != DEPTH_C) || pop);

    // The memory address comes straight from a register, so out_ready never
    // reaches imem_addr combinationally.
    assign imem_addr   = fetch_pc[ADDR_WIDTH+1:2];
    assign out_instr   = entry_instr[rd_ptr];
    assign out_pc      = entry_pc[rd_ptr];
    assign queue_count = count;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC_ALIGNED;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc_aligned;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + 1'b1;
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the entry storage is reset on purpose: out_pc/out_instr must read
    // zero straight out of reset, and a reset must leave no partial entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                entry_pc[i]    <= '0;
                entry_instr[i] <= '0;
            end
        end else if (push) begin
            entry_pc[wr_ptr]    <= fetch_pc;
            entry_instr[wr_ptr] <= imem_data;
        end
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch controller that sequences the combinational instruction memory (2^ADDR_WIDTH words of 32 bits, asynchronous read).
- Holds the fetch PC and drives the word address to the memory.
- Captures each returned instruction with its PC into a small in-order fetch queue.
- Presents the queue head to decode through a valid/ready handshake; supports branch/jump redirect with queue flush, plus a fetch-enable stall.

Parameters:
ADDR_WIDTH, 5, instruction memory word-address width (memory depth 2^ADDR_WIDTH words).
RESET_PC, 32'h0000_0000, byte PC loaded at reset; bits [1:0] ignored (treated as 0).
QUEUE_DEPTH, 2, fetch queue entries; power of two, 2..8.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-high reset.
fetch_en  input  1  1 = fetch allowed; 0 = hold PC, no new pushes.
redirect_valid  input  1  1 = flush queue and restart fetch at redirect_pc.
redirect_pc  input  32  new byte PC; bits [1:0] forced to 0.
imem_addr  output  ADDR_WIDTH  word address to instruction memory = fetch_pc[ADDR_WIDTH+1:2].
imem_data  input  32  instruction returned combinationally for imem_addr.
out_valid  output  1  queue head valid to decode.
out_ready  input  1  decode accepts head.
out_instr  output  32  head instruction.
out_pc  output  32  head byte PC.
queue_count  output  $clog2(QUEUE_DEPTH)+1  current occupancy.

Behaviour:
- Reset (async, rst=1):
  - fetch_pc = {RESET_PC[31:2],2'b00}; queue empty (count=0, rd/wr pointers 0); all entry storage = 0.
  - Outputs: out_valid=0, out_instr=0, out_pc=0, queue_count=0, imem_addr=RESET_PC[ADDR_WIDTH+1:2].
- Signal definitions:
  - pop = out_valid && out_ready.
  - out_valid = (count!=0) && !redirect_valid. This is a combinational mask; no pop can occur on a redirect cycle.
  - push = fetch_en && !redirect_valid && (count<QUEUE_DEPTH || pop).
- Push: the entry {fetch_pc, imem_data} is written at wr_ptr on the clock edge; fetch_pc <= fetch_pc+4 (32-bit, wraps 0xFFFF_FFFC -> 0). Latency is one cycle: an instruction addressed in cycle N is at out_instr in cycle N+1 when the queue was empty.
- Push and pop in the same cycle: count is unchanged. When full, this allows one instruction per cycle sustained throughput.
- Full (count==QUEUE_DEPTH) and no pop: no push; fetch_pc holds; imem_addr stable.
- Empty: out_valid=0; out_instr/out_pc show stale head storage (don't-care for the checker).
- Redirect (redirect_valid=1, highest priority over push, pop and fetch_en):
  - count <= 0; rd_ptr, wr_ptr <= 0; fetch_pc <= {redirect_pc[31:2],2'b00}.
  - The next cycle fetches from the new PC if fetch_en=1.
- fetch_en=0: no push; pops continue; fetch_pc holds.
- Memory index wrap: imem_addr is fetch_pc[ADDR_WIDTH+1:2]; PCs >= 4*2^ADDR_WIDTH alias modulo memory size. out_pc always carries the full 32-bit PC.
- Queue pointers: log2(QUEUE_DEPTH) bits, wrap naturally; count saturates at QUEUE_DEPTH by construction.
- Reset asserted mid-operation: immediate return to the reset state regardless of handshake; no partial entry survives.
- All state updates occur on the rising clk edge; no combinational path from out_ready to imem_addr.

Test Plan:
- Reset then fetch_en=1, out_ready=1, memory word k = 0x1000_0000+k: out_pc 0x0,0x4,0x8... on consecutive cycles with out_instr 0x1000_0000,0x1000_0001,...; first out_valid one cycle after reset release.
- out_ready=0 for 5 cycles: queue_count rises to 2 and holds; imem_addr freezes at word 2. Then out_ready=1: PCs 0x0,0x4,0x8 delivered in order, none lost or duplicated.
- redirect_valid=1 with redirect_pc=0x0000_0016 while queue is full: out_valid=0 that cycle; queue_count=0 next cycle; next delivered out_pc=0x14 with memory word 5.
- fetch_en=0 for 3 cycles with out_ready=1: queue drains to 0 and fetch_pc holds. Re-enable: fetch resumes at the held PC with no skipped address.
- Wrap: redirect to 0x7C (ADDR_WIDTH=5) gives out_pc 0x7C, 0x80 with imem_addr 31 then 0; out_instr = word 31 then word 0.
- Assert rst for 1 cycle mid-stream with queue_count=1: out_valid=0 immediately (asynchronously); after release, fetch restarts at RESET_PC.
